mm_result_buffer: RTL and testbench

MM_RESULT_BUFFER -- requirements
Module: mm_result_buffer

---
 rtl/mm_result_buffer.sv | 126 ++++++++++++
 tb/tb_mm_result_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_result_buffer.sv
// mm_result_buffer: in-order result FIFO for a pipelined multiplier.
// It tracks issued-but-unreturned operations (in-flight credit) so that
// upstream only issues when a buffer slot is guaranteed. Dropped results
// and credit misuse raise sticky error flags.
// Optional feature: define MM_RESBUF_SEQ_EN to tag each stored entry with
// an 8-bit sequence number shown on out_seq. When it is undefined, out_seq
// is tied to zero.
module mm_result_buffer #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     issue,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         Q,
  output logic                     can_issue,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_overflow,
  output logic                     err_credit,
  output logic [7:0]               out_seq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    inflight_next;
  logic [CW:0]      credit_sum_next;
  logic             push;
  logic             pop;
  logic             full;

  // Handshake decode plus next-state count and in-flight credit.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pop           = (count != '0) && out_ready;
    full          = (count == DEPTH_C);
    push          = in_valid && (!full || pop);
    count_next    = count;
    inflight_next = inflight;

    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end

    // A return with nothing in flight leaves the credit at zero; an issue
    // beyond the limit saturates at DEPTH.
    if (issue && !in_valid) begin
      if (inflight != DEPTH_C) inflight_next = inflight + CW'(1);
    end else if (!issue && in_valid) begin
      if (inflight != '0) inflight_next = inflight - CW'(1);
    end

    credit_sum_next = {1'b0, inflight_next} + {1'b0, count_next};
  end

  // Control state: pointers, occupancy, credit, issue permission, error flags.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      inflight     <= '0;
      can_issue    <= 1'b1;
      err_overflow <= 1'b0;
      err_credit   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count        <= count_next;
      inflight     <= inflight_next;
      can_issue    <= (credit_sum_next < {1'b0, DEPTH_C});
      err_overflow <= err_overflow | (in_valid && !push);
      err_credit   <= err_credit | (in_valid && (inflight == '0))
                                 | (issue && !can_issue);
    end
  end

  // Result storage write; a result arriving during reset is discarded.
  // NOTE: the storage array is deliberately not reset; out_valid masks stale
  // contents, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (push && !reset) mem[wr_ptr] <= Q;
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

`ifdef MM_RESBUF_SEQ_EN
  logic [7:0] seq_cnt;
  logic [7:0] seq_mem [DEPTH];

  // Sequence counter advances once per accepted push and wraps 255 -> 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      seq_cnt <= '0;
    end else if (push) begin
      seq_cnt <= seq_cnt + 8'd1;
    end
  end

  // Tag storage written alongside the result.
  always_ff @(posedge clock) begin
    if (push && !reset) seq_mem[wr_ptr] <= seq_cnt;
  end

  // Show zero while empty so out_seq is defined right after reset.
  assign out_seq = out_valid ? seq_mem[rd_ptr] : 8'd0;
`else
  assign out_seq = 8'd0;
`endif

endmodule

// File: tb/tb_mm_result_buffer.sv
// tb_mm_result_buffer: directed self-checking bench for mm_result_buffer
// with the default WIDTH=256, DEPTH=8 configuration.
module tb_mm_result_buffer;

  localparam int WIDTH = 256;
  localparam int DEPTH = 8;

  logic             clock;
  logic             reset;
  logic             issue;
  logic             in_valid;
  logic [WIDTH-1:0] Q;
  logic             can_issue;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [3:0]       count;
  logic             err_overflow;
  logic             err_credit;
  logic [7:0]       out_seq;

  int n_vec;
  int n_err;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [7:0]       s;
  } ent_t;

  ent_t sb[$];

  localparam logic [WIDTH-1:0] SINGLE_Q =
    256'h7aa790fb_1c2d3e4f_50617283_94a5b6c7_d8e9fa0b_1c2d3e4f_0badcafe_deed84e0;

  mm_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .issue        (issue),
    .in_valid     (in_valid),
    .Q            (Q),
    .can_issue    (can_issue),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .err_overflow (err_overflow),
    .err_credit   (err_credit),
    .out_seq      (out_seq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] mk(input int i);
    logic [31:0] w;
    w = 32'h9e3779b9 ^ 32'(i * 32'h01010101);
    return {w, ~w, w + 32'd1, w ^ 32'h5a5a5a5a, w, 32'(i), ~w, w - 32'd7};
  endfunction

  function automatic logic [7:0] exp_seq(input int i);
`ifdef MM_RESBUF_SEQ_EN
    return 8'(i);
`else
    return 8'd0;
`endif
  endfunction

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    issue     = 1'b0;
    in_valid  = 1'b0;
    Q         = '0;
    out_ready = 1'b0;

    // Reset state.
    tick();
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_can_issue", can_issue, 1);
    chk("rst_err_ovf", err_overflow, 0);
    chk("rst_err_credit", err_credit, 0);
    chk("rst_seq", out_seq, 0);

    // Single operation: issue, latency gap, result, then consumed.
    issue = 1'b1;
    tick();
    issue = 1'b0;
    chk("single_can_issue_inflight", can_issue, 1);
    tick();
    tick();
    in_valid  = 1'b1;
    Q         = SINGLE_Q;
    out_ready = 1'b1;
    chk("single_no_bypass", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, SINGLE_Q);
    chk("single_count1", count, 1);
    tick();
    chk("single_popped", out_valid, 0);
    chk("single_count0", count, 0);
    chk("single_can_issue", can_issue, 1);
    chk("single_err_credit", err_credit, 0);

    // Credit fill: eight back-to-back issues with the consumer stalled.
    out_ready = 1'b0;
    issue     = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("fill_can_issue_7", can_issue, 1);
    tick();
    issue = 1'b0;
    chk("fill_can_issue_8", can_issue, 0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      Q        = mk(i);
      tick();
    end
    in_valid = 1'b0;
    chk("fill_count", count, 8);
    chk("fill_head", out_data, mk(0));
    chk("fill_can_issue_full", can_issue, 0);
    chk("fill_err_ovf", err_overflow, 0);
    chk("fill_err_credit", err_credit, 0);

    // Full with simultaneous push and pop, then a dropped result.
    in_valid  = 1'b1;
    Q         = mk(8);
    out_ready = 1'b1;
    tick();
    chk("full_pp_count", count, 8);
    chk("full_pp_head", out_data, mk(1));
    chk("full_pp_err_ovf", err_overflow, 0);
    Q         = mk(9);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("full_drop_count", count, 8);
    chk("full_drop_head", out_data, mk(1));
    chk("full_drop_err_ovf", err_overflow, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", out_data, mk(i));
      tick();
    end
    chk("drain_count", count, 0);
    chk("drain_valid", out_valid, 0);
    tick();
    chk("pop_empty_count", count, 0);
    chk("sticky_err_ovf", err_overflow, 1);

    // Ordering under toggling backpressure against a scoreboard.
    out_ready = 1'b0;
    do_reset();
    begin
      int   pushed;
      logic do_pop;
      ent_t e;
      pushed = 0;
      for (int c = 0; c < 40 && (pushed < 10 || sb.size() > 0); c++) begin
        in_valid  = (pushed < 10);
        Q         = mk(100 + pushed);
        out_ready = (c % 2 == 0);
        chk("ord_valid", out_valid, (sb.size() > 0));
        if (sb.size() > 0) begin
          chk("ord_data", out_data, sb[0].d);
          chk("ord_seq", out_seq, sb[0].s);
        end
        do_pop = (sb.size() > 0) && out_ready;
        tick();
        if (do_pop) void'(sb.pop_front());
        if (in_valid) begin
          e.d = mk(100 + pushed);
          e.s = exp_seq(pushed);
          sb.push_back(e);
          pushed++;
        end
        chk("ord_count", count, sb.size());
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("ord_drained", sb.size(), 0);
      chk("ord_err_ovf", err_overflow, 0);
    end

    // Credit error: a result with nothing in flight is still stored.
    do_reset();
    in_valid = 1'b1;
    Q        = mk(55);
    tick();
    in_valid = 1'b0;
    chk("cred_rx_err", err_credit, 1);
    chk("cred_rx_count", count, 1);
    chk("cred_rx_data", out_data, mk(55));

    // Credit error: issuing past the limit.
    do_reset();
    chk("cred_iss_clear", err_credit, 0);
    issue = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("cred_iss_ok8", err_credit, 0);
    tick();
    issue = 1'b0;
    chk("cred_iss_err", err_credit, 1);

    // Build count=5, inflight=2 (inflight saturated at 8), then reset.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      Q        = mk(200 + i);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mid_count", count, 5);
    chk("mid_can_issue", can_issue, 1);
    chk("mid_head", out_data, mk(201));
    reset    = 1'b1;
    in_valid = 1'b1;
    Q        = mk(300);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_can_issue", can_issue, 1);
    chk("mid_rst_err_credit", err_credit, 0);
    chk("mid_rst_err_ovf", err_overflow, 0);
    tick();
    chk("mid_rst_ignored_rx", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
